apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- Single-channel APB master that sits directly upstream of apb_slave and drives its psel/penable/paddr/pwrite/pwdata while sampling pready/prdata.
- Accepts one transfer request at a time on a valid/ready command port.
- Runs the APB IDLE→SETUP→ACCESS sequence and returns read data or a timeout status on a valid/ready response port.
- Replaces the behavioural dummy master currently used to exercise apb_slave.

Parameters:
ADDR_W, 32, paddr / req_addr width
DATA_W, 32, pwdata / prdata / req_wdata / rsp_rdata width
TIMEOUT, 16, max ACCESS-phase cycles with pready low before abort; 0 disables timeout
TO_W, 5, timeout counter width; must satisfy 2**TO_W > TIMEOUT

Ports:
pclk  in  1  clock, all logic on rising edge
preset  in  1  asynchronous active-low reset
req_valid  in  1  command request valid
req_ready  out  1  command accepted when req_valid & req_ready
req_addr  in  ADDR_W  transfer address
req_write  in  1  1=write, 0=read
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data from slave
pready  in  1  APB slave ready

Behaviour:
- Clock port is pclk. Reset port is preset: asynchronous, active-low. Assertion forces all state and outputs to reset values immediately, independent of pclk.
- Reset values: all outputs 0, except req_ready. req_ready is combinational and goes to 1 in IDLE once preset deasserts. State=IDLE, timeout counter=0.
- Registered outputs: psel, penable, paddr, pwrite, pwdata, rsp_valid, rsp_rdata, rsp_timeout.
- States:
  - IDLE: psel=0, penable=0. On req accept, latch addr/write/wdata into paddr/pwrite/pwdata and go to SETUP.
  - SETUP (exactly 1 cycle): psel=1, penable=0. pready is ignored. Unconditionally go to ACCESS.
  - ACCESS: psel=1, penable=1.
    - pready=1: go to RESP. Capture rsp_rdata=prdata for reads, 0 for writes. rsp_timeout=0. Drop psel/penable.
    - pready=0: increment counter. If TIMEOUT≠0 and counter reaches TIMEOUT, go to RESP with rsp_timeout=1, rsp_rdata=0, and drop psel/penable.
  - RESP: rsp_valid=1 and held with rsp_rdata/rsp_timeout stable until rsp_ready.
    - rsp_ready with no accepted request: go to IDLE.
    - rsp_ready with a request accepted the same cycle: go directly to SETUP (back-to-back).
- req_ready = (state==IDLE) | (state==RESP & rsp_ready). It is combinational from state and rsp_ready only, with no path from req_valid.
- paddr/pwrite/pwdata are stable from SETUP through the end of ACCESS. They hold their last values while idle and change only on request accept.
- Timeout counter clears on entering SETUP. It saturates and never wraps.
- Minimum latency: accept at edge N, SETUP at N+1, ACCESS at N+2; with pready=1, rsp_valid=1 at N+3. Each pready-low ACCESS cycle adds 1.
- pready=1 on the same edge the counter would reach TIMEOUT: the completion wins and rsp_timeout=0.
- penable never rises without psel. psel never deasserts mid-ACCESS except on completion or timeout.
- Reset during SETUP/ACCESS: the bus drops immediately, no response is issued, and the request is lost.

Decomposition:
- Shared package/include apb_defs holds:
  - state encoding localparams (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3);
  - the default ADDR_W/DATA_W.
- apb_slave and the bench use the same defs.
- One natural sub-module: apb_wait_timer. It is the saturating TO_W-bit counter with clear/enable inputs and an expired output, and is reusable by the slave-side wait logic.

Test Plan:
- Reset: assert preset low mid-run → all outputs 0 immediately. After release: req_ready=1, psel=0.
- Single write: addr=32'h0000_0010, wdata=32'hA5A5_5A5A, pready=1 at ACCESS → psel 1 for 2 cycles, penable 1 for 1 cycle, pwrite=1 → rsp_valid 3 cycles after accept with rdata=0, timeout=0.
- Read with 3 wait states: pready low 3 ACCESS cycles, then high with prdata=32'hDEAD_BEEF → rsp_rdata=32'hDEAD_BEEF. paddr stable throughout. rsp_valid at accept+6.
- Timeout: TIMEOUT=4, pready tied 0 → psel/penable drop after 4 ACCESS cycles, rsp_timeout=1, rsp_rdata=0. Also check pready rising exactly on cycle 4 → normal completion.
- Back-to-back with backpressure: rsp_ready held 0 for 5 cycles, then 1 together with req_valid → rsp_valid held stable 5 cycles, then next SETUP on the following cycle with no IDLE gap.
- Reset mid-ACCESS against apb_slave → bus idle at once, no rsp_valid. The next request completes normally.

Source files
------------

// File: rtl/apb_defs.sv
// Shared APB definitions: FSM state encoding and default bus widths.
package apb_defs;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SETUP  = SETUP,
    ST_ACCESS = ACCESS,
    ST_RESP   = RESP
  } apb_state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // True when a TO_W-bit counter can hold the timeout limit without wrapping.
  function automatic bit apb_to_w_ok(input int timeout, input int to_w);
    return (64'd1 << to_w) > 64'(timeout);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter. o_expired flags the enabled increment that
// lands on LIMIT, so the owner can act on the same edge. LIMIT=0 never expires.
module apb_wait_timer #(
  parameter int TO_W  = 5,
  parameter int LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TO_W:0] LIM = (TO_W+1)'(LIMIT);

  logic [TO_W-1:0] r_count;
  logic [TO_W:0]   w_next;
  logic            w_sat;

  assign w_next    = {1'b0, r_count} + {{TO_W{1'b0}}, 1'b1};
  assign w_sat     = (r_count == {TO_W{1'b1}});
  assign o_expired = (LIMIT != 0) && i_en && (w_next >= LIM);

  // Count enabled cycles, holding at all-ones rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_sat) begin
      r_count <= w_next[TO_W-1:0];
    end
  end

endmodule

// File: rtl/apb_master.sv
// Single-channel APB master: one request at a time in, one response out.
//
// state  | meaning
// IDLE   | bus idle, ready for a request
// SETUP  | psel=1, penable=0 for exactly one cycle
// ACCESS | psel=1, penable=1, waiting on pready or timeout
// RESP   | rsp_valid held until rsp_ready; may accept the next request
module apb_master
  import apb_defs::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  apb_state_e        r_state;
  logic              r_psel;
  logic              r_penable;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_timeout;

  logic w_req_ready;
  logic w_accept;
  logic w_tmr_en;
  logic w_expired;

  // Ready depends only on state and rsp_ready; held low while in reset.
  assign w_req_ready = preset &
                       ((r_state == ST_IDLE) | ((r_state == ST_RESP) & rsp_ready));
  assign w_accept    = req_valid & w_req_ready;
  assign w_tmr_en    = (r_state == ST_ACCESS) & ~pready;

  assign req_ready   = w_req_ready;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;

  // Wait-state counter, cleared whenever a request moves us into SETUP.
  apb_wait_timer #(
    .TO_W  (TO_W),
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .i_clk     (pclk),
    .i_rst_n   (preset),
    .i_clr     (w_accept),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  // Transfer sequencing with all bus and response outputs registered.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_state       <= ST_IDLE;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_paddr  <= req_addr;
            r_pwrite <= req_write;
            r_pwdata <= req_wdata;
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // Completion takes priority over a timeout landing on the same edge.
          if (pready) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_pwrite ? '0 : prdata;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_RESP;
          end else if (w_expired) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b1;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
            if (w_accept) begin
              r_paddr  <= req_addr;
              r_pwrite <= req_write;
              r_pwdata <= req_wdata;
              r_psel   <= 1'b1;
              r_state  <= ST_SETUP;
            end else begin
              r_state  <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Randomised bench for apb_master with a scoreboarded response monitor and a
// behavioural APB slave that inserts a chosen number of wait states.
module tb_apb_master;
  import apb_defs::*;

  localparam int AW  = APB_ADDR_W;
  localparam int DW  = APB_DATA_W;
  localparam int TMO = 4;
  localparam int TOW = 3;

  logic          pclk = 1'b0;
  logic          preset;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_write = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;

  apb_master #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO),
    .TO_W    (TOW)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wd;
    int            w;
    logic [DW-1:0] rd;
    int            acc;
  } bus_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          tmo;
    int            cyc;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int bp_cnt   = 0;
  bit rnd_rdy  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_psel"}, psel, 0);
    chk({tag, "_penable"}, penable, 0);
    chk({tag, "_paddr"}, paddr, 0);
    chk({tag, "_pwrite"}, pwrite, 0);
    chk({tag, "_pwdata"}, pwdata, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
  endtask

  task automatic drive_rdy();
    if (bp_cnt > 0 && rsp_valid) begin
      rsp_ready = 1'b0;
      bp_cnt--;
    end else if (rnd_rdy) begin
      rsp_ready = ($urandom_range(3) != 0);
    end else begin
      rsp_ready = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pclk);
      drive_rdy();
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_write = $urandom_range(1);
      req_wdata = $urandom;
      #1;
    end
  endtask

  // Expected outcome from the transfer rules: w low-pready ACCESS cycles
  // before pready rises; w >= TMO means the master gives up after TMO cycles.
  task automatic issue(input logic [AW-1:0] addr, input logic wr,
                       input logic [DW-1:0] wd, input int w, input logic [DW-1:0] rd);
    bus_t b;
    rsp_t r;
    int   k;
    bit   done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge pclk);
      drive_rdy();
      req_valid = 1'b1;
      req_addr  = addr;
      req_write = wr;
      req_wdata = wd;
      #1;
      if (req_ready) begin
        done   = 1'b1;
        b.addr = addr;
        b.wr   = wr;
        b.wd   = wd;
        b.w    = w;
        b.rd   = rd;
        b.acc  = cyc + 1;
        bus_q.push_back(b);
        k       = (w >= TMO) ? TMO : w + 1;
        r.tmo   = (w >= TMO);
        r.rdata = (wr || w >= TMO) ? '0 : rd;
        r.cyc   = b.acc + 1 + k;
        rsp_q.push_back(r);
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_accept: req_ready never 1, required 1 within 300 cycles");
    end
  endtask

  // Behavioural APB slave plus bus-protocol checks.
  initial begin
    bus_t cur;
    int   acnt;
    bit   have;
    acnt = 0;
    have = 1'b0;
    forever begin
      @(negedge pclk);
      if (!preset) begin
        bus_q.delete();
        have   = 1'b0;
        pready = 1'b0;
        prdata = '0;
      end else if (psel && !penable) begin
        if (bus_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_setup: psel=1 with no request outstanding");
          have = 1'b0;
        end else begin
          cur  = bus_q.pop_front();
          have = 1'b1;
          chk("setup_cycle", cyc, cur.acc);
          chk("setup_paddr", paddr, cur.addr);
          chk("setup_pwrite", pwrite, cur.wr);
          chk("setup_pwdata", pwdata, cur.wd);
        end
        acnt   = 0;
        pready = $urandom_range(1);
        prdata = $urandom;
      end else if (psel && penable) begin
        if (have) begin
          chk("access_paddr", paddr, cur.addr);
          chk("access_pwrite", pwrite, cur.wr);
          chk("access_pwdata", pwdata, cur.wd);
          chk("access_len", acnt < TMO, 1);
          pready = (acnt == cur.w);
          prdata = pready ? cur.rd : DW'($urandom);
        end else begin
          pready = 1'b1;
          prdata = $urandom;
        end
        acnt++;
      end else begin
        chk("penable_without_psel", penable, 0);
        pready = $urandom_range(1);
        prdata = $urandom;
      end
    end
  end

  // Response monitor: pops the scoreboard when a new response appears.
  initial begin
    rsp_t          e;
    bit            showing;
    logic [DW-1:0] hd;
    logic          ht;
    showing = 1'b0;
    hd      = '0;
    ht      = 1'b0;
    forever begin
      @(negedge pclk);
      #2;
      if (!preset) begin
        rsp_q.delete();
        showing = 1'b0;
      end else if (rsp_valid) begin
        if (!showing) begin
          if (rsp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: rsp_valid=1 with nothing expected at cycle %0d", cyc);
          end else begin
            e = rsp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_timeout", rsp_timeout, e.tmo);
            chk("rsp_cycle", cyc, e.cyc);
          end
          showing = 1'b1;
          hd      = rsp_rdata;
          ht      = rsp_timeout;
        end else begin
          chk("rsp_hold_rdata", rsp_rdata, hd);
          chk("rsp_hold_timeout", rsp_timeout, ht);
        end
        if (rsp_ready) showing = 1'b0;
      end else begin
        showing = 1'b0;
      end
    end
  end

  // Stimulus: directed cases first, then randomised traffic.
  initial begin
    bit hit;
    preset = 1'b1;
    #1 preset = 1'b0;
    #2;
    chk_all_zero("por");
    @(negedge pclk);
    #3 preset = 1'b1;
    #1;
    chk("rel_req_ready", req_ready, 1);
    chk("rel_psel", psel, 0);

    rnd_rdy = 1'b0;
    issue(32'h0000_0010, 1'b1, 32'hA5A5_5A5A, 0, 32'h0BAD_0BAD);
    idle(4);
    issue(32'h0000_0020, 1'b0, 32'h0, 3, 32'hDEAD_BEEF);
    idle(8);
    issue(32'h0000_0030, 1'b0, 32'h0, 99, 32'h1234_5678);
    idle(8);
    issue(32'h0000_0034, 1'b1, 32'h7777_7777, 99, 32'h0);
    idle(8);
    issue(32'h0000_0040, 1'b0, 32'h0, TMO - 1, 32'hCAFE_F00D);
    idle(8);

    issue(32'h0000_0050, 1'b1, 32'h0000_1111, 0, 32'h0);
    bp_cnt = 5;
    issue(32'h0000_0060, 1'b0, 32'h0, 1, 32'h2222_3333);
    idle(10);

    // Reset in the middle of ACCESS.
    issue(32'h0000_0070, 1'b0, 32'h0, 99, 32'h4444_5555);
    hit = 1'b0;
    for (int t = 0; t < 50 && !hit; t++) begin
      @(negedge pclk);
      drive_rdy();
      req_valid = 1'b0;
      #1;
      if (psel && penable) hit = 1'b1;
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL reach_access: never saw ACCESS, required within 50 cycles");
    end
    #2 preset = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge pclk);
    #3 preset = 1'b1;
    #1;
    chk("midrst_rel_req_ready", req_ready, 1);
    chk("midrst_rel_psel", psel, 0);
    idle(6);
    issue(32'h0000_0080, 1'b0, 32'h0, 1, 32'h0000_BEEF);
    idle(8);

    rnd_rdy = 1'b1;
    repeat (80) begin
      issue(AW'($urandom), 1'($urandom_range(1)), DW'($urandom),
            $urandom_range(TMO + 1), DW'($urandom));
      if ($urandom_range(1) != 0) idle($urandom_range(3));
    end

    rnd_rdy = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 300 && !hit; t++) begin
      idle(1);
      if (rsp_q.size() == 0 && !rsp_valid && !psel) hit = 1'b1;
    end
    if (!hit) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d responses still outstanding, required 0", rsp_q.size());
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
